mcif_read_eg_cq: RTL and testbench

//  Per-thread context queue between the MCIF read ingress converter and the read egress.
//  - Ingress writes one 7-bit context entry per issued AXI AR: cq_wr_* carries a thread_id and a pd.
//  - Egress pops one entry from the matching thread FIFO as each read return completes.
//  - Each thread is an independent in-order FIFO, so the egress sees per-client ordering.

---
 rtl/mcif_read_eg_cq_if.sv | 26 ++
 rtl/mcif_read_eg_cq.sv | 106 ++++++++++
 tb/tb_mcif_read_eg_cq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mcif_read_eg_cq_if.sv
// Context-queue bus: ingress write handshake plus per-thread egress head/pop lanes.
interface mcif_read_eg_cq_if #(
    parameter int unsigned NUM_THREADS = 10,
    parameter int unsigned PD_W        = 7
);
    logic                          cq_wr_pvld;
    logic                          cq_wr_prdy;
    logic [3:0]                    cq_wr_thread_id;
    logic [PD_W-1:0]               cq_wr_pd;
    logic                          cq_wr_err;
    logic [NUM_THREADS-1:0]        cq_rd_pvld;
    logic [NUM_THREADS-1:0]        cq_rd_prdy;
    logic [NUM_THREADS*PD_W-1:0]   cq_rd_pd;

    // Ingress/egress clients drive requests and pops
    modport master (
        output cq_wr_pvld, cq_wr_thread_id, cq_wr_pd, cq_rd_prdy,
        input  cq_wr_prdy, cq_wr_err, cq_rd_pvld, cq_rd_pd
    );

    // The queue itself
    modport slave (
        input  cq_wr_pvld, cq_wr_thread_id, cq_wr_pd, cq_rd_prdy,
        output cq_wr_prdy, cq_wr_err, cq_rd_pvld, cq_rd_pd
    );
endinterface

// File: rtl/mcif_read_eg_cq.sv
// Per-thread in-order context queue between MCIF read ingress and read egress.
// One write port shared by all threads, one independent pop lane per thread.
module mcif_read_eg_cq #(
    parameter int unsigned NUM_THREADS = 10,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned PD_W        = 7
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    mcif_read_eg_cq_if.slave cq
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PD_W-1:0] mem_q    [NUM_THREADS][DEPTH];
    logic [PD_W-1:0] mem_d    [NUM_THREADS][DEPTH];
    logic [PtrW-1:0] wr_ptr_q [NUM_THREADS];
    logic [PtrW-1:0] wr_ptr_d [NUM_THREADS];
    logic [PtrW-1:0] rd_ptr_q [NUM_THREADS];
    logic [PtrW-1:0] rd_ptr_d [NUM_THREADS];
    logic [CntW-1:0] cnt_q    [NUM_THREADS];
    logic [CntW-1:0] cnt_d    [NUM_THREADS];
    logic            err_q;
    logic            err_d;

    logic                   tid_ok;
    logic                   wr_prdy;
    logic                   wr_fire;
    logic [NUM_THREADS-1:0] full;
    logic [NUM_THREADS-1:0] push;
    logic [NUM_THREADS-1:0] pop;

    // Write acceptance: out-of-range ids are always accepted, then dropped and flagged
    always_comb begin
        tid_ok = {28'd0, cq.cq_wr_thread_id} < NUM_THREADS;
        for (int t = 0; t < NUM_THREADS; t++) begin
            full[t] = (cnt_q[t] == CntW'(DEPTH));
        end
        wr_prdy = 1'b1;
        if (tid_ok) begin
            // Uses registered count only: a same-cycle pop does not free a full FIFO
            wr_prdy = ~full[cq.cq_wr_thread_id];
        end
        wr_fire = cq.cq_wr_pvld & wr_prdy;
        err_d   = wr_fire & ~tid_ok;
    end

    // Per-thread next-state: storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        push     = '0;
        pop      = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            push[t] = wr_fire & tid_ok & (cq.cq_wr_thread_id == 4'(t));
            pop[t]  = (cnt_q[t] != '0) & cq.cq_rd_prdy[t];
            if (push[t]) begin
                mem_d[t][wr_ptr_q[t]] = cq.cq_wr_pd;
                wr_ptr_d[t]           = wr_ptr_q[t] + PtrW'(1);
            end
            if (pop[t]) begin
                rd_ptr_d[t] = rd_ptr_q[t] + PtrW'(1);
            end
            case ({push[t], pop[t]})
                2'b10:   cnt_d[t] = cnt_q[t] + CntW'(1);
                2'b01:   cnt_d[t] = cnt_q[t] - CntW'(1);
                default: cnt_d[t] = cnt_q[t];
            endcase
        end
    end

    // Outputs: head valid/data come purely from flops
    always_comb begin
        cq.cq_wr_prdy = wr_prdy;
        cq.cq_wr_err  = err_q;
        cq.cq_rd_pvld = '0;
        cq.cq_rd_pd   = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            cq.cq_rd_pvld[t]              = (cnt_q[t] != '0);
            cq.cq_rd_pd[t*PD_W +: PD_W]   = mem_q[t][rd_ptr_q[t]];
        end
    end

    // State registers with synchronous reset clearing storage too
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    mem_q[t][d] <= '0;
                end
                wr_ptr_q[t] <= '0;
                rd_ptr_q[t] <= '0;
                cnt_q[t]    <= '0;
            end
            err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_mcif_read_eg_cq.sv
// Bench for mcif_read_eg_cq: vector table plus hand sequences, per-thread queue scoreboard.
module tb_mcif_read_eg_cq;
    localparam int unsigned NT    = 10;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PDW   = 7;

    logic clk;
    logic rst;

    mcif_read_eg_cq_if #(.NUM_THREADS(NT), .PD_W(PDW)) cq ();

    mcif_read_eg_cq #(
        .NUM_THREADS (NT),
        .DEPTH       (DEPTH),
        .PD_W        (PDW)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cq             (cq.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;

    // Scoreboard: expected contents of each thread FIFO, oldest first
    logic [PDW-1:0] mq [NT][$];
    logic           err_exp;
    logic           prdy_seen;

    typedef struct {
        logic          wv;
        logic [3:0]    tid;
        logic [PDW-1:0] pd;
        logic [NT-1:0] rp;
        logic          exp_prdy;
        logic [NT-1:0] exp_pvld;
        logic          exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus with scoreboard update and post-edge checks
    task automatic step(input logic wv, input logic [3:0] tid, input logic [PDW-1:0] pd,
                        input logic [NT-1:0] rp, input string nm);
        logic           exp_prdy;
        logic [PDW-1:0] exp_v;
        logic [NT-1:0]  exp_pvld;
        @(negedge clk);
        cq.cq_wr_pvld      = wv;
        cq.cq_wr_thread_id = tid;
        cq.cq_wr_pd        = pd;
        cq.cq_rd_prdy      = rp;
        #1;
        exp_prdy  = (tid >= 4'(NT)) ? 1'b1 : (mq[tid].size() != DEPTH);
        prdy_seen = cq.cq_wr_prdy;
        chk({nm, " prdy"}, 80'(cq.cq_wr_prdy), 80'(exp_prdy));
        for (int t = 0; t < NT; t++) begin
            if (rp[t] && mq[t].size() > 0) begin
                exp_v = mq[t].pop_front();
                chk({nm, " pop pd"}, 80'(cq.cq_rd_pd[t*PDW +: PDW]), 80'(exp_v));
            end
        end
        err_exp = 1'b0;
        if (wv && exp_prdy) begin
            if (tid < 4'(NT)) mq[tid].push_back(pd);
            else err_exp = 1'b1;
        end
        @(posedge clk);
        #1;
        cq.cq_wr_pvld = 1'b0;
        cq.cq_rd_prdy = '0;
        exp_pvld = '0;
        for (int t = 0; t < NT; t++) begin
            exp_pvld[t] = (mq[t].size() != 0);
            if (mq[t].size() != 0) begin
                chk({nm, " head"}, 80'(cq.cq_rd_pd[t*PDW +: PDW]), 80'(mq[t][0]));
            end
        end
        chk({nm, " pvld"}, 80'(cq.cq_rd_pvld), 80'(exp_pvld));
        chk({nm, " err"}, 80'(cq.cq_wr_err), 80'(err_exp));
    endtask

    task automatic peek_prdy(input logic [3:0] tid, input logic exp, input string nm);
        @(negedge clk);
        cq.cq_wr_pvld      = 1'b0;
        cq.cq_wr_thread_id = tid;
        cq.cq_rd_prdy      = '0;
        #1;
        chk(nm, 80'(cq.cq_wr_prdy), 80'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        err_exp = 1'b0;
        prdy_seen = 1'b0;
        rst = 1'b1;
        cq.cq_wr_pvld      = 1'b0;
        cq.cq_wr_thread_id = '0;
        cq.cq_wr_pd        = '0;
        cq.cq_rd_prdy      = '0;

        //            wv    tid  pd     rp          prdy  pvld     err
        vecs[0] = '{1'b1, 4'd2,  7'h15, 10'h000, 1'b1, 10'h004, 1'b0};
        vecs[1] = '{1'b1, 4'd3,  7'h11, 10'h000, 1'b1, 10'h00C, 1'b0};
        vecs[2] = '{1'b1, 4'd3,  7'h2A, 10'h008, 1'b1, 10'h00C, 1'b0};
        vecs[3] = '{1'b1, 4'd12, 7'h33, 10'h000, 1'b1, 10'h00C, 1'b1};
        vecs[4] = '{1'b0, 4'd0,  7'h00, 10'h000, 1'b1, 10'h00C, 1'b0};
        vecs[5] = '{1'b0, 4'd0,  7'h00, 10'h00C, 1'b1, 10'h000, 1'b0};
        vecs[6] = '{1'b1, 4'd4,  7'h01, 10'h010, 1'b1, 10'h010, 1'b0};
        vecs[7] = '{1'b0, 4'd0,  7'h00, 10'h010, 1'b1, 10'h000, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset pvld", 80'(cq.cq_rd_pvld), 80'(0));
        chk("reset pd", 80'(cq.cq_rd_pd), 80'(0));
        chk("reset err", 80'(cq.cq_wr_err), 80'(0));
        chk("reset prdy", 80'(cq.cq_wr_prdy), 80'(1));

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].wv, vecs[i].tid, vecs[i].pd, vecs[i].rp, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl prdy", i), 80'(prdy_seen), 80'(vecs[i].exp_prdy));
            chk($sformatf("vec%0d tbl pvld", i), 80'(cq.cq_rd_pvld), 80'(vecs[i].exp_pvld));
            chk($sformatf("vec%0d tbl err", i), 80'(cq.cq_wr_err), 80'(vecs[i].exp_err));
        end
        // err is a single-cycle pulse
        step(1'b0, 4'd0, 7'h00, 10'h000, "err_clear");

        // Fill thread 5, check full/non-full ready, drain in order
        for (int i = 0; i < 8; i++) step(1'b1, 4'd5, 7'(i), 10'h000, "fill5");
        peek_prdy(4'd5, 1'b0, "full5 prdy");
        peek_prdy(4'd4, 1'b1, "thread4 prdy");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'd0, 7'h00, 10'h020, "drain5");
            chk($sformatf("drain5 pvld5 #%0d", i), 80'(cq.cq_rd_pvld[5]), 80'(i < 7));
        end

        // Full FIFO: a same-cycle pop does not let the write in
        for (int i = 0; i < 8; i++) step(1'b1, 4'd5, 7'(8'h40 + i), 10'h000, "refill5");
        step(1'b1, 4'd5, 7'h7F, 10'h020, "full_wr_pop");
        chk("full_wr_pop refused", 80'(prdy_seen), 80'(0));
        step(1'b1, 4'd5, 7'h7F, 10'h000, "retry_wr");
        chk("retry_wr accepted", 80'(prdy_seen), 80'(1));
        peek_prdy(4'd5, 1'b0, "refull5 prdy");
        for (int i = 0; i < 8; i++) step(1'b0, 4'd0, 7'h00, 10'h020, "drain5b");

        // Mid-stream reset wipes all threads
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd0, 7'(8'h10 + i), 10'h000, "fill0");
            step(1'b1, 4'd1, 7'(8'h20 + i), 10'h000, "fill1");
            step(1'b1, 4'd9, 7'(8'h30 + i), 10'h000, "fill9");
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst pvld", 80'(cq.cq_rd_pvld), 80'(0));
        chk("midrst pd", 80'(cq.cq_rd_pd), 80'(0));
        for (int t = 0; t < NT; t++) mq[t].delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 4'd0, 7'h5A, 10'h000, "postrst_wr");
        chk("postrst head0", 80'(cq.cq_rd_pd[PDW-1:0]), 80'(7'h5A));
        chk("postrst pvld", 80'(cq.cq_rd_pvld), 80'(10'h001));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
